// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M/RV64M multiply/divide unit for the execute stage.
// Shift-add multiply and restoring divide, one bit per cycle, with a
// start/busy/done handshake. Divide-by-zero and signed overflow are resolved
// without iterating.
// Optional build macro: MULDIV_FAST_MUL_EN -- multiplies use a single-cycle
// XLEN x XLEN multiplier and skip the iterative CALC phase.
module muldiv_unit #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int unsigned PW = 2 * XLEN;
    localparam int unsigned RW = XLEN + 1;
    localparam int unsigned CW = $clog2(XLEN);

    localparam logic [2:0] F_MUL    = 3'b000;
    localparam logic [2:0] F_MULH   = 3'b001;
    localparam logic [2:0] F_MULHSU = 3'b010;
    localparam logic [2:0] F_MULHU  = 3'b011;
    localparam logic [2:0] F_DIV    = 3'b100;
    localparam logic [2:0] F_DIVU   = 3'b101;
    localparam logic [2:0] F_REM    = 3'b110;
    localparam logic [2:0] F_REMU   = 3'b111;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREP,
        S_CALC,
        S_FIX,
        S_DONE
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic            w_busy_nxt;
    logic            w_done_nxt;

    logic [2:0]      r_op;
    logic [XLEN-1:0] r_a;
    logic [XLEN-1:0] r_b;
    logic [XLEN-1:0] r_mag;      // multiplicand or divisor magnitude
    logic [PW-1:0]   r_prod;     // {partial sum, remaining multiplier bits}
    logic [XLEN-1:0] r_quot;     // dividend bits shift out, quotient bits shift in
    logic [RW-1:0]   r_rem;
    logic            r_neg;      // negate product / quotient in FIX
    logic            r_rem_neg;  // negate remainder in FIX
    logic [CW-1:0]   r_cnt;
    logic            r_busy;
    logic            r_done;
    logic [XLEN-1:0] r_result;

    logic            w_is_div;
    logic            w_a_signed;
    logic            w_b_signed;
    logic            w_a_neg;
    logic            w_b_neg;
    logic [XLEN-1:0] w_a_mag;
    logic [XLEN-1:0] w_b_mag;
    logic            w_div_zero;
    logic            w_div_ovf;
    logic            w_special;
    logic            w_fast_mul;
    logic            w_last;
    logic [RW-1:0]   w_sum;
    logic [RW-1:0]   w_trial;
    logic [RW-1:0]   w_diff;
    logic            w_fits;
    logic [PW-1:0]   w_prod_fix;
    logic [XLEN-1:0] w_quot_fix;
    logic [XLEN-1:0] w_rem_fix;
    logic [XLEN-1:0] w_res_sel;

    assign busy   = r_busy;
    assign done   = r_done;
    assign result = r_result;

    // Operand decode: signedness, magnitudes and divide corner cases
    always_comb begin
        w_is_div   = r_op[2];
        w_a_signed = (r_op == F_MULH) || (r_op == F_MULHSU) || (r_op == F_DIV) || (r_op == F_REM);
        w_b_signed = (r_op == F_MULH) || (r_op == F_DIV) || (r_op == F_REM);
        w_a_neg    = w_a_signed & r_a[XLEN-1];
        w_b_neg    = w_b_signed & r_b[XLEN-1];
        w_a_mag    = w_a_neg ? (-r_a) : r_a;
        w_b_mag    = w_b_neg ? (-r_b) : r_b;
        w_div_zero = w_is_div && (r_b == '0);
        w_div_ovf  = w_is_div && !r_op[0] && (r_a == {1'b1, {(XLEN-1){1'b0}}}) && (r_b == '1);
        w_special  = w_div_zero | w_div_ovf;
`ifdef MULDIV_FAST_MUL_EN
        w_fast_mul = !w_is_div;
`else
        w_fast_mul = 1'b0;
`endif
        w_last     = (r_cnt == CW'(XLEN - 1));
    end

    // One-bit iteration datapaths: shift-add multiply and restoring divide
    always_comb begin
        w_sum   = r_prod[0] ? ({1'b0, r_prod[PW-1:XLEN]} + {1'b0, r_mag})
                            : {1'b0, r_prod[PW-1:XLEN]};
        w_trial = RW'({r_rem, r_quot[XLEN-1]});
        w_diff  = w_trial - {1'b0, r_mag};
        w_fits  = !w_diff[XLEN];
    end

    // Sign fix-up and result select
    always_comb begin
        w_prod_fix = r_neg ? (-r_prod) : r_prod;
        w_quot_fix = r_neg ? (-r_quot) : r_quot;
        w_rem_fix  = r_rem_neg ? (-r_rem[XLEN-1:0]) : r_rem[XLEN-1:0];
        case (r_op)
            F_MUL:                     w_res_sel = w_prod_fix[XLEN-1:0];
            F_MULH, F_MULHSU, F_MULHU: w_res_sel = w_prod_fix[PW-1:XLEN];
            F_DIV, F_DIVU:             w_res_sel = w_quot_fix;
            F_REM, F_REMU:             w_res_sel = w_rem_fix;
            default:                   w_res_sel = w_quot_fix;
        endcase
    end

    // Next-state logic and next values of the handshake outputs
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (start) w_state_nxt = S_PREP;
            S_PREP: w_state_nxt = (w_special || w_fast_mul) ? S_FIX : S_CALC;
            S_CALC: if (w_last) w_state_nxt = S_FIX;
            S_FIX:  w_state_nxt = S_DONE;
            S_DONE: w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
        w_busy_nxt = (w_state_nxt == S_PREP) || (w_state_nxt == S_CALC) || (w_state_nxt == S_FIX);
        w_done_nxt = (w_state_nxt == S_DONE);
    end

    // State register and registered handshake outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
        end
    end

    // Operand capture, iteration and result registers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_op      <= '0;
            r_a       <= '0;
            r_b       <= '0;
            r_mag     <= '0;
            r_prod    <= '0;
            r_quot    <= '0;
            r_rem     <= '0;
            r_neg     <= 1'b0;
            r_rem_neg <= 1'b0;
            r_cnt     <= '0;
            r_result  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_op <= funct3;
                        r_a  <= a;
                        r_b  <= b;
                    end
                end
                S_PREP: begin
                    r_cnt     <= '0;
                    r_neg     <= w_a_neg ^ w_b_neg;
                    r_rem_neg <= w_a_neg;
                    r_mag     <= w_is_div ? w_b_mag : w_a_mag;
                    r_prod    <= {{XLEN{1'b0}}, w_b_mag};
                    r_quot    <= w_a_mag;
                    r_rem     <= '0;
                    if (w_div_zero) begin
                        r_quot    <= '1;
                        r_rem     <= {1'b0, r_a};
                        r_neg     <= 1'b0;
                        r_rem_neg <= 1'b0;
                    end else if (w_div_ovf) begin
                        r_quot    <= r_a;
                        r_rem     <= '0;
                        r_neg     <= 1'b0;
                        r_rem_neg <= 1'b0;
                    end
`ifdef MULDIV_FAST_MUL_EN
                    if (w_fast_mul) begin
                        r_prod <= PW'(w_a_mag) * PW'(w_b_mag);
                    end
`endif
                end
                S_CALC: begin
                    r_cnt <= r_cnt + CW'(1);
                    if (w_is_div) begin
                        r_rem  <= w_fits ? w_diff : w_trial;
                        r_quot <= {r_quot[XLEN-2:0], w_fits};
                    end else begin
                        r_prod <= {w_sum, r_prod[XLEN-1:1]};
                    end
                end
                S_FIX: begin
                    r_result <= w_res_sel;
                end
                default: begin
                end
            endcase
        end
    end

endmodule
